// File: rtl/fetch_unit.sv
// Fetch unit: owns the PC, requests 16-byte aligned blocks from the I-cache and
// writes left-justified instruction bundles into the fetch queue.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int unsigned             addressWidth            = 64,
  parameter int unsigned             instructionWidth        = 32,
  parameter int unsigned             maxBundleSize           = 128,
  parameter int unsigned             PidSize                 = 32,
  parameter int unsigned             TidSize                 = 64,
  parameter int unsigned             instructionCounterWidth = 64,
  parameter logic [addressWidth-1:0] resetVector             = '0
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [PidSize-1:0]                 pid_i,
  input  logic [TidSize-1:0]                 tid_i,
  input  logic                               redirect_i,
  input  logic [addressWidth-1:0]            redirectAddress_i,
  output logic                               icacheReq_o,
  output logic [addressWidth-1:0]            icacheAddress_o,
  input  logic                               icacheAck_i,
  input  logic [maxBundleSize-1:0]           icacheData_i,
  input  logic                               queueFull_i,
  output logic                               bundleWrite_o,
  output logic [addressWidth-1:0]            bundleAddress_o,
  output logic [1:0]                         bundleLen_o,
  output logic [PidSize-1:0]                 bundlePid_o,
  output logic [TidSize-1:0]                 bundleTid_o,
  output logic [instructionCounterWidth-1:0] bundleStartMajId_o,
  output logic [maxBundleSize-1:0]           bundle_o
);

  localparam int unsigned AW     = addressWidth;
  localparam int unsigned CW     = instructionCounterWidth;
  localparam int unsigned ShiftW = $clog2(maxBundleSize);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT, S_HOLD} state_t;

  state_t                   r_state, w_next_state;
  logic [AW-1:0]            r_pc, w_next_pc, w_redirect_pc, w_next_block, w_pc_step;
  logic [CW-1:0]            r_maj_id, w_next_maj_id, w_maj_step;
  logic                     r_discard, w_next_discard;
  logic                     w_latch, w_fire;
  logic [1:0]               w_slot, w_len;
  logic [2:0]               w_count;
  logic [ShiftW-1:0]        w_shift;

  logic                     r_req;
  logic [AW-1:0]            r_req_addr;
  logic                     r_write;
  logic [AW-1:0]            r_b_addr;
  logic [1:0]               r_b_len;
  logic [PidSize-1:0]       r_b_pid;
  logic [TidSize-1:0]       r_b_tid;
  logic [CW-1:0]            r_b_maj;
  logic [maxBundleSize-1:0] r_bundle;
  logic                     w_unused;

  // Slot of the PC within its block determines how many instructions the bundle carries.
  assign w_slot        = r_pc[3:2];
  assign w_len         = 2'd3 - w_slot;
  assign w_count       = {1'b0, w_len} + 3'd1;
  assign w_pc_step     = AW'({w_count, 2'b00});
  assign w_maj_step    = CW'(w_count);
  assign w_shift       = ShiftW'(w_slot) * ShiftW'(instructionWidth);
  assign w_redirect_pc = {redirectAddress_i[AW-1:2], 2'b00};
  assign w_next_block  = {w_next_pc[AW-1:4], 4'b0000};
  assign w_unused      = ^redirectAddress_i[1:0];

  always_comb begin
    w_next_state   = r_state;
    w_next_pc      = r_pc;
    w_next_maj_id  = r_maj_id;
    w_next_discard = r_discard;
    w_latch        = 1'b0;
    w_fire         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (redirect_i) begin
          w_next_pc = w_redirect_pc;
        end else if (enable_i) begin
          w_next_state = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (redirect_i) begin
          w_next_pc    = w_redirect_pc;
          w_next_state = S_REQUEST;
        end else begin
          w_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // A redirect without its ack leaves one stale ack to swallow.
        if (redirect_i) begin
          w_next_pc = w_redirect_pc;
          if (icacheAck_i) begin
            w_next_discard = 1'b0;
            w_next_state   = S_REQUEST;
          end else begin
            w_next_discard = 1'b1;
          end
        end else if (icacheAck_i) begin
          if (r_discard) begin
            w_next_discard = 1'b0;
            w_next_state   = S_REQUEST;
          end else begin
            w_latch = 1'b1;
            if (queueFull_i) begin
              w_next_state = S_HOLD;
            end else begin
              w_fire       = 1'b1;
              w_next_state = enable_i ? S_REQUEST : S_IDLE;
            end
          end
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          w_next_pc    = w_redirect_pc;
          w_next_state = S_REQUEST;
        end else if (!queueFull_i) begin
          w_fire       = 1'b1;
          w_next_state = enable_i ? S_REQUEST : S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    // PC and major id advance together with the write pulse.
    if (w_fire) begin
      w_next_pc     = r_pc + w_pc_step;
      w_next_maj_id = r_maj_id + w_maj_step;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_pc       <= resetVector;
      r_maj_id   <= '0;
      r_discard  <= 1'b0;
      r_req      <= 1'b0;
      r_req_addr <= '0;
      r_write    <= 1'b0;
      r_b_addr   <= '0;
      r_b_len    <= '0;
      r_b_pid    <= '0;
      r_b_tid    <= '0;
      r_b_maj    <= '0;
      r_bundle   <= '0;
    end else begin
      r_state   <= w_next_state;
      r_pc      <= w_next_pc;
      r_maj_id  <= w_next_maj_id;
      r_discard <= w_next_discard;
      r_req     <= (w_next_state == S_REQUEST);
      if (w_next_state == S_REQUEST) begin
        r_req_addr <= w_next_block;
      end
      r_write <= w_fire;
      if (w_latch) begin
        r_b_addr <= r_pc;
        r_b_len  <= w_len;
        r_b_pid  <= pid_i;
        r_b_tid  <= tid_i;
        r_b_maj  <= r_maj_id;
        r_bundle <= icacheData_i << w_shift;
      end
    end
  end

  assign icacheReq_o        = r_req;
  assign icacheAddress_o    = r_req_addr;
  assign bundleWrite_o      = r_write;
  assign bundleAddress_o    = r_b_addr;
  assign bundleLen_o        = r_b_len;
  assign bundlePid_o        = r_b_pid;
  assign bundleTid_o        = r_b_tid;
  assign bundleStartMajId_o = r_b_maj;
  assign bundle_o           = r_bundle;

endmodule
